// File: rtl/sd_cmd_pkg.sv
// Shared constants and types for the SD command response path.
// Frame lengths, CRC7 polynomial, CRC ranges and receiver states.
package sd_cmd_pkg;

   localparam int SHORT_BITS     = 48;
   localparam int LONG_BITS      = 136;
   localparam int BITS_COUNTER   = 8;
   localparam int TIMEOUT_CYCLES = 64;
   localparam int TIMER_BITS     = 7;

   localparam logic [6:0] CRC7_POLY = 7'h09;

   // Indices (arrival order) covered by CRC7
   localparam int SHORT_CRC_LO = 0;
   localparam int SHORT_CRC_HI = 39;
   localparam int LONG_CRC_LO  = 8;
   localparam int LONG_CRC_HI  = 127;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_WAIT_START,
      ST_RECEIVE,
      ST_DONE
   } rx_state_e;

endpackage

// File: rtl/sd_cmd_response_receiver_if.sv
// Handshake bundle between command controller and response receiver.
// master = controller side, slave = receiver side.
interface sd_cmd_response_receiver_if;
   import sd_cmd_pkg::*;

   logic                 start;
   logic                 long_resp;
   logic                 check_crc;
   logic                 cmd_in;
   logic [LONG_BITS-1:0] resp;
   logic                 busy;
   logic                 done;
   logic                 crc_err;
   logic                 frame_err;
   logic                 timeout;

   modport master (
      output start, long_resp, check_crc, cmd_in,
      input  resp, busy, done, crc_err, frame_err, timeout
   );

   modport slave (
      input  start, long_resp, check_crc, cmd_in,
      output resp, busy, done, crc_err, frame_err, timeout
   );

endinterface

// File: rtl/sd_crc7.sv
// Serial CRC7 (x^7+x^3+1), MSB-first, with synchronous clear.
// Shared by the command frame builder and the response receiver.
module sd_crc7
   import sd_cmd_pkg::*;
(
   input  logic       clk,
   input  logic       reset,
   input  logic       clr,
   input  logic       en,
   input  logic       bit_in,
   output logic [6:0] crc
);

   logic [6:0] crc_q, crc_d;
   logic       fb;

   always_comb begin
      crc_d = crc_q;
      fb    = bit_in ^ crc_q[6];
      if (clr) begin
         crc_d = '0;
      end else if (en) begin
         crc_d = {crc_q[5:0], 1'b0} ^ (fb ? CRC7_POLY : 7'h00);
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) crc_q <= '0;
      else       crc_q <= crc_d;
   end

   assign crc = crc_q;

endmodule

// File: rtl/sd_cmd_response_receiver.sv
// SD CMD-line response receiver: waits for start bit, captures
// a 48/136-bit frame, checks CRC7 and framing, flags timeout.
module sd_cmd_response_receiver
   import sd_cmd_pkg::*;
(
   input logic                       clk,
   input logic                       reset,
   sd_cmd_response_receiver_if.slave bus
);

   rx_state_e               state_q, state_d;
   logic [BITS_COUNTER-1:0] idx_q, idx_d;
   logic [TIMER_BITS-1:0]   timer_q, timer_d;
   logic [LONG_BITS-1:0]    resp_q, resp_d;
   logic busy_q, busy_d;
   logic done_q, done_d;
   logic crc_err_q, crc_err_d;
   logic frame_err_q, frame_err_d;
   logic timeout_q, timeout_d;
   logic long_q, long_d;
   logic chk_q, chk_d;

   logic                    crc_clr, crc_en;
   logic [6:0]              crc;
   logic [BITS_COUNTER-1:0] lo_idx, hi_idx, last_idx;
   logic [2:0]              crc_sel;
   logic                    in_crc, in_cmp;

   assign lo_idx   = long_q ? BITS_COUNTER'(LONG_CRC_LO)
                            : BITS_COUNTER'(SHORT_CRC_LO);
   assign hi_idx   = long_q ? BITS_COUNTER'(LONG_CRC_HI)
                            : BITS_COUNTER'(SHORT_CRC_HI);
   assign last_idx = long_q ? BITS_COUNTER'(LONG_BITS - 1)
                            : BITS_COUNTER'(SHORT_BITS - 1);
   assign in_crc   = (idx_q >= lo_idx) && (idx_q <= hi_idx);
   assign in_cmp   = (idx_q > hi_idx) && (idx_q < last_idx);
   // First received CRC bit (hi+1) maps to crc[6]; mod-8 math suffices
   assign crc_sel  = hi_idx[2:0] + 3'd7 - idx_q[2:0];

   always_comb begin
      state_d     = state_q;
      idx_d       = idx_q;
      timer_d     = timer_q;
      resp_d      = resp_q;
      busy_d      = busy_q;
      done_d      = 1'b0;
      crc_err_d   = crc_err_q;
      frame_err_d = frame_err_q;
      timeout_d   = timeout_q;
      long_d      = long_q;
      chk_d       = chk_q;
      crc_clr     = 1'b0;
      crc_en      = 1'b0;
      unique case (state_q)
         ST_IDLE, ST_DONE: begin
            state_d = ST_IDLE;
            if (bus.start) begin
               long_d      = bus.long_resp;
               chk_d       = bus.check_crc;
               resp_d      = '0;
               crc_err_d   = 1'b0;
               frame_err_d = 1'b0;
               timeout_d   = 1'b0;
               crc_clr     = 1'b1;
               timer_d     = '0;
               idx_d       = '0;
               busy_d      = 1'b1;
               state_d     = ST_WAIT_START;
            end
         end
         ST_WAIT_START: begin
            if (!bus.cmd_in) begin
               resp_d[0] = 1'b0;
               idx_d     = BITS_COUNTER'(1);
               crc_en    = (lo_idx == '0);
               state_d   = ST_RECEIVE;
            end else if (timer_q == TIMER_BITS'(TIMEOUT_CYCLES - 1)) begin
               timeout_d = 1'b1;
               busy_d    = 1'b0;
               done_d    = 1'b1;
               state_d   = ST_DONE;
            end else begin
               timer_d = timer_q + 1'b1;
            end
         end
         ST_RECEIVE: begin
            resp_d[idx_q] = bus.cmd_in;
            crc_en        = in_crc;
            if (idx_q == BITS_COUNTER'(1) && bus.cmd_in)
               frame_err_d = 1'b1;
            if (in_cmp && chk_q && (bus.cmd_in != crc[crc_sel]))
               crc_err_d = 1'b1;
            if (idx_q == last_idx) begin
               if (!bus.cmd_in) frame_err_d = 1'b1;
               busy_d  = 1'b0;
               done_d  = 1'b1;
               state_d = ST_DONE;
            end else begin
               idx_d = idx_q + 1'b1;
            end
         end
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q     <= ST_IDLE;
         idx_q       <= '0;
         timer_q     <= '0;
         resp_q      <= '0;
         busy_q      <= 1'b0;
         done_q      <= 1'b0;
         crc_err_q   <= 1'b0;
         frame_err_q <= 1'b0;
         timeout_q   <= 1'b0;
         long_q      <= 1'b0;
         chk_q       <= 1'b0;
      end else begin
         state_q     <= state_d;
         idx_q       <= idx_d;
         timer_q     <= timer_d;
         resp_q      <= resp_d;
         busy_q      <= busy_d;
         done_q      <= done_d;
         crc_err_q   <= crc_err_d;
         frame_err_q <= frame_err_d;
         timeout_q   <= timeout_d;
         long_q      <= long_d;
         chk_q       <= chk_d;
      end
   end

   sd_crc7 u_crc (
      .clk    (clk),
      .reset  (reset),
      .clr    (crc_clr),
      .en     (crc_en),
      .bit_in (bus.cmd_in),
      .crc    (crc)
   );

   assign bus.resp      = resp_q;
   assign bus.busy      = busy_q;
   assign bus.done      = done_q;
   assign bus.crc_err   = crc_err_q;
   assign bus.frame_err = frame_err_q;
   assign bus.timeout   = timeout_q;

endmodule

// File: doc/sd_cmd_response_receiver.md
Name: sd_cmd_response_receiver

Overview:
- Downstream companion of the SD host command serializer.
- After a command has been shifted out, it samples the SD CMD line and waits for a card response.
- Captures a 48-bit (R1/R3/R6/R7) or 136-bit (R2) response frame, computes CRC7 serially and checks the framing bits.
- Reports completion, errors and timeout to the command controller.

Parameters:
- LONG_BITS, 136, length of R2 frame
- SHORT_BITS, 48, length of all other response frames
- BITS_COUNTER, 8, width of bit index; must cover LONG_BITS
- TIMEOUT_CYCLES, 64, max clk cycles between start and response start bit (NCR)
- TIMER_BITS, 7, width of timeout counter; must cover TIMEOUT_CYCLES

Ports:
- clk  in  1  sampling clock (SD clock domain, same as serializer)
- reset  in  1  reset, asynchronous, active-high
- start  in  1  one-cycle pulse: arm receiver for a new response
- long_resp  in  1  1 = expect 136-bit frame, 0 = 48-bit; sampled with start
- check_crc  in  1  1 = verify CRC7 (0 for R3); sampled with start
- cmd_in  in  1  CMD line input, idle high
- resp  out  LONG_BITS  captured frame; first received bit at resp[0] (matches serializer's in[0]-first order); short frames use resp[47:0], upper bits 0
- busy  out  1  high from accepted start until done
- done  out  1  one-cycle pulse, flags valid in same cycle
- crc_err  out  1  CRC7 mismatch (only if check_crc)
- frame_err  out  1  transmission bit != 0 or end bit != 1
- timeout  out  1  no start bit within TIMEOUT_CYCLES

Behaviour:
- Reset (async): state IDLE; resp, busy, done, crc_err, frame_err, timeout, counters, crc all 0.
- States: IDLE, WAIT_START, RECEIVE, DONE.
- IDLE or DONE, start=1:
  - latch long_resp and check_crc; clear resp, flags and crc.
  - timer=0, go to WAIT_START; busy=1 from the next cycle.
- start while busy is ignored.
- WAIT_START, each posedge:
  - cmd_in=0 → store resp[0]=0, index=1, go to RECEIVE.
  - else timer+1; when timer reaches TIMEOUT_CYCLES-1 with cmd_in=1 → timeout=1, go to DONE.
- RECEIVE, each posedge:
  - resp[index]=cmd_in, index+1.
- CRC7 (poly x^7+x^3+1, init 0) is fed in arrival order, MSB-of-frame first:
  - short frame: indices 0..39
  - long frame: indices 8..127
- Index 1 (transmission bit): cmd_in=1 sets frame_err.
- After the last CRC-covered bit, the next 7 received bits are compared to crc (first received = crc[6]). Any mismatch with check_crc=1 sets crc_err.
- Last index (N-1) is the end bit: cmd_in=0 sets frame_err. On that edge go to DONE.
- DONE (one cycle):
  - done=1, busy=0; flags and resp stable; next cycle go to IDLE.
  - Flags and resp hold until the next accepted start.
- Latency:
  - done asserts exactly 1 cycle after the end bit is sampled.
  - On timeout, done asserts TIMEOUT_CYCLES+1 cycles after start.
- Reset mid-frame: immediate return to IDLE, partial data discarded.
- Simultaneous start and done: start is accepted (DONE accepts start).
- Index counter never exceeds N-1; no wrap-around.

Decomposition:
- Package sd_cmd_pkg:
  - SHORT_BITS/LONG_BITS constants
  - CRC7 polynomial 7'h09
  - receiver state encoding
  - CRC range bounds (short 0..39, long 8..127)
- Sub-module sd_crc7: serial CRC7 with clear, enable and bit inputs and a 7-bit crc output. It is reused by the command frame builder upstream of the serializer.

Test Plan:
- R7 good: start, long_resp=0, check_crc=1; after 5 idle cycles drive frame 0x08000001AA13 MSB first → done, resp[47:0] bit-reversed frame, crc_err=0, frame_err=0, timeout=0.
- CRC error: same frame with arg byte 0xAA→0xAB (CRC still 0x09) → done, crc_err=1, frame_err=0.
- Framing: drive host frame 0x400000000095 (tx bit 1, valid CRC 0x4A) → frame_err=1, crc_err=0. Separately, 0x08000001AA12 (end bit 0) → frame_err=1.
- R3 no-CRC: check_crc=0, frame 0x3F80FF8000FF → crc_err=0, frame_err=0, resp holds OCR 0x80FF8000 (reversed).
- Timeout: start, hold cmd_in=1 → done exactly 65 cycles after start, timeout=1, resp=0. Start during busy is ignored.
- R2 long: 136-bit frame with golden-model CRC → crc_err=0, done 1 cycle after bit 135. Assert reset at bit 70 → all outputs 0 and IDLE; a new start works.
